key_serializer: RTL and testbench

//  Upstream feeder for the serial key-sequence detector. Accepts a parallel key code over a

---
 rtl/key_serial_pkg.sv | 14 +
 rtl/key_serializer.sv | 163 ++++++++++++++++
 tb/tb_key_serializer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/key_serial_pkg.sv
// Shared types and defaults for the key serializer and the key-sequence detector bench.
package key_serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } ser_state_t;

    localparam int unsigned DEFAULT_CODE_W = 4;
    localparam int unsigned DEFAULT_GAP    = 2;

endpackage

// File: rtl/key_serializer.sv
// Parallel-to-serial feeder for the key-sequence detector.
// Accepts a code over valid/ready, shifts it out one bit per clock on d_out,
// then holds d_out low for GAP_CYCLES so consecutive frames never merge.
// Optional feature: define SERIAL_PARITY_EN to append an even-parity bit.
module key_serializer
    import key_serial_pkg::*;
#(
    parameter int unsigned CODE_W     = DEFAULT_CODE_W,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              d_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BW = $clog2(CODE_W + 1);
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(CODE_W);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    ser_state_t        r_state;
    logic [CODE_W-1:0] r_shift;
    logic [BW-1:0]     r_bit_cnt;
    logic [GW-1:0]     r_gap_cnt;
    logic              r_d_out;
    logic              r_done;

    ser_state_t        w_state_nx;
    logic [CODE_W-1:0] w_shift_nx;
    logic [BW-1:0]     w_bit_cnt_nx;
    logic [GW-1:0]     w_gap_cnt_nx;
    logic              w_d_out_nx;
    logic              w_done_nx;
    logic              w_accept;

`ifdef SERIAL_PARITY_EN
    logic              r_parity;
    logic              w_parity_nx;
`endif

    // Bit that leaves first for a given word, honouring the send order.
    function automatic logic lead_bit(input logic [CODE_W-1:0] v);
        return MSB_FIRST ? v[CODE_W-1] : v[0];
    endfunction

    // Word with its leading bit consumed, next bit moved into lead position.
    function automatic logic [CODE_W-1:0] consume(input logic [CODE_W-1:0] v);
        return MSB_FIRST ? {v[CODE_W-2:0], 1'b0} : {1'b0, v[CODE_W-1:1]};
    endfunction

    assign w_accept   = code_valid && (r_state == IDLE);
    assign code_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign d_out      = r_d_out;
    assign done       = r_done;

    // Next-state and next-output decode; d_out is registered so every bit
    // appears the cycle after the edge that decides it. The first bit is
    // driven straight from code on the accept edge, so bit_cnt counts bits
    // already placed on d_out rather than bits still pending.
    always_comb begin
        w_state_nx   = r_state;
        w_shift_nx   = r_shift;
        w_bit_cnt_nx = r_bit_cnt;
        w_gap_cnt_nx = r_gap_cnt;
        w_d_out_nx   = 1'b0;
        w_done_nx    = 1'b0;
`ifdef SERIAL_PARITY_EN
        w_parity_nx  = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nx   = SHIFT;
                    w_d_out_nx   = lead_bit(code);
                    w_shift_nx   = consume(code);
                    w_bit_cnt_nx = BW'(1);
                    w_gap_cnt_nx = '0;
`ifdef SERIAL_PARITY_EN
                    w_parity_nx  = ^code;
`endif
                end
            end
            SHIFT: begin
                if (r_bit_cnt == BIT_LAST) begin
`ifdef SERIAL_PARITY_EN
                    w_state_nx = PARITY;
                    w_d_out_nx = r_parity;
`else
                    if (GAP_CYCLES > 0) begin
                        w_state_nx   = GAP;
                        w_gap_cnt_nx = GAP_ONE;
                    end else begin
                        w_state_nx = IDLE;
                        w_done_nx  = 1'b1;
                    end
`endif
                end else begin
                    w_d_out_nx   = lead_bit(r_shift);
                    w_shift_nx   = consume(r_shift);
                    w_bit_cnt_nx = r_bit_cnt + BW'(1);
                end
            end
            PARITY: begin
`ifdef SERIAL_PARITY_EN
                if (GAP_CYCLES > 0) begin
                    w_state_nx   = GAP;
                    w_gap_cnt_nx = GAP_ONE;
                end else begin
                    w_state_nx = IDLE;
                    w_done_nx  = 1'b1;
                end
`else
                w_state_nx = IDLE;
`endif
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nx = IDLE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_gap_cnt_nx = r_gap_cnt + GW'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_d_out   <= 1'b0;
            r_done    <= 1'b0;
`ifdef SERIAL_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nx;
            r_shift   <= w_shift_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_gap_cnt <= w_gap_cnt_nx;
            r_d_out   <= w_d_out_nx;
            r_done    <= w_done_nx;
`ifdef SERIAL_PARITY_EN
            r_parity  <= w_parity_nx;
`endif
        end
    end

endmodule

// File: tb/tb_key_serializer.sv
// Self-checking bench for key_serializer: three instances (MSB-first with gap,
// LSB-first with gap, MSB-first without gap) share clock and reset.
// Expected per-cycle outputs {d_out,busy,done,code_ready} are queued as
// stimulus is driven and popped on each falling edge.
module tb_key_serializer;

`ifdef SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic reset;

    logic [3:0] code_m, code_l, code_g;
    logic       valid_m, valid_l, valid_g;
    logic       ready_m, ready_l, ready_g;
    logic       d_m, d_l, d_g;
    logic       busy_m, busy_l, busy_g;
    logic       done_m, done_l, done_g;

    logic [3:0] obs_m, obs_l, obs_g;
    assign obs_m = {d_m, busy_m, done_m, ready_m};
    assign obs_l = {d_l, busy_l, done_l, ready_l};
    assign obs_g = {d_g, busy_g, done_g, ready_g};

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    key_serializer #(.CODE_W(4), .GAP_CYCLES(2), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .code(code_m), .code_valid(valid_m),
        .code_ready(ready_m), .d_out(d_m), .busy(busy_m), .done(done_m));

    key_serializer #(.CODE_W(4), .GAP_CYCLES(2), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .code(code_l), .code_valid(valid_l),
        .code_ready(ready_l), .d_out(d_l), .busy(busy_l), .done(done_l));

    key_serializer #(.CODE_W(4), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) dut_g (
        .clk(clk), .reset(reset), .code(code_g), .code_valid(valid_g),
        .code_ready(ready_g), .d_out(d_g), .busy(busy_g), .done(done_g));

    // Expected cycles for one frame accepted at the previous edge.
    function automatic void push_frame(input logic [3:0] c, input bit msb, input int gap);
        for (int k = 0; k < 4; k++)
            exp_q.push_back({(msb ? c[3-k] : c[k]), 3'b100});
        if (PAR != 0)
            exp_q.push_back({^c, 3'b100});
        for (int k = 0; k < gap; k++)
            exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0011);
    endfunction

    function automatic void push_idle(input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back(4'b0001);
    endfunction

    task automatic test_reset();
        logic [3:0] e;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b0;
            e = 4'b0001;
            checks++;
            if (obs_m !== e) begin errors++; $display("FAIL reset_m cyc %0d: got %b want %b", i, obs_m, e); end
            checks++;
            if (obs_l !== e) begin errors++; $display("FAIL reset_l cyc %0d: got %b want %b", i, obs_l, e); end
            checks++;
            if (obs_g !== e) begin errors++; $display("FAIL reset_g cyc %0d: got %b want %b", i, obs_g, e); end
        end
    endtask

    task automatic test_msb_frame();
        logic [3:0] e;
        int idx = 0;
        code_m = 4'b1011; valid_m = 1'b1;
        push_frame(4'b1011, 1'b1, 2);
        push_idle(2);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_m !== e) begin errors++; $display("FAIL msb_frame cyc %0d: got %b want %b", idx, obs_m, e); end
            if (idx == 0) begin valid_m = 1'b0; code_m = 4'b0000; end
            idx++;
        end
    endtask

    task automatic test_lsb_frame();
        logic [3:0] e;
        int idx = 0;
        code_l = 4'b1011; valid_l = 1'b1;
        push_frame(4'b1011, 1'b0, 2);
        push_idle(2);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_l !== e) begin errors++; $display("FAIL lsb_frame cyc %0d: got %b want %b", idx, obs_l, e); end
            if (idx == 0) begin valid_l = 1'b0; code_l = 4'b0100; end
            idx++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        int idx = 0;
        int flen = 4 + PAR + 2 + 1;
        code_m = 4'b1111; valid_m = 1'b1;
        push_frame(4'b1111, 1'b1, 2);
        push_frame(4'b0001, 1'b1, 2);
        push_idle(3);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_m !== e) begin errors++; $display("FAIL back_to_back cyc %0d: got %b want %b", idx, obs_m, e); end
            if (idx == 0) code_m = 4'b0001;
            if (idx == flen) valid_m = 1'b0;
            if (idx == flen + 2) begin valid_m = 1'b1; code_m = 4'b1111; end
            if (idx == flen + 3) valid_m = 1'b0;
            idx++;
        end
    endtask

    task automatic test_no_gap();
        logic [3:0] e;
        int idx = 0;
        code_g = 4'b1011; valid_g = 1'b1;
        push_frame(4'b1011, 1'b1, 0);
        push_idle(2);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_g !== e) begin errors++; $display("FAIL no_gap cyc %0d: got %b want %b", idx, obs_g, e); end
            if (idx == 0) valid_g = 1'b0;
            idx++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] e;
        int idx = 0;
        code_m = 4'b1011; valid_m = 1'b1;
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0100);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_m !== e) begin errors++; $display("FAIL abort_bits cyc %0d: got %b want %b", idx, obs_m, e); end
            if (idx == 0) valid_m = 1'b0;
            idx++;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_m !== 4'b0001) begin errors++; $display("FAIL abort_reset: got %b want 0001", obs_m); end
        reset = 1'b0;
        push_idle(2);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_m !== e) begin errors++; $display("FAIL abort_idle cyc %0d: got %b want %b", idx, obs_m, e); end
            idx++;
        end
        code_m = 4'b1011; valid_m = 1'b1;
        push_frame(4'b1011, 1'b1, 2);
        push_idle(1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_m !== e) begin errors++; $display("FAIL abort_resend cyc %0d: got %b want %b", idx, obs_m, e); end
            if (idx == 0) valid_m = 1'b0;
            idx++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        code_m  = '0; code_l  = '0; code_g  = '0;
        valid_m = 1'b0; valid_l = 1'b0; valid_g = 1'b0;
        test_reset();
        test_msb_frame();
        test_lsb_frame();
        test_back_to_back();
        test_no_gap();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
